intr_ctrl: RTL
==============

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops per external request line (legal 2..4).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 forces reset state immediately).
REQ-004 irq1  input  1  external interrupt request line 1, asynchronous, rising-edge significant.
REQ-005 irq2  input  1  external interrupt request line 2, asynchronous, rising-edge significant.
REQ-006 we_mask  input  1  load mask register from mask_in this cycle.
REQ-007 mask_in  input  2  enable bits: [0] line 1, [1] line 2 (1 = enabled).
REQ-008 iret  input  1  CPU return-from-interrupt strobe, one cycle, ends current service.
REQ-009 clr_lost  input  1  clear both sticky lost bits.
REQ-010 s_intr1  output  1  one-cycle pulse: CPU vectors to interrupt 1.
REQ-011 s_intr2  output  1  one-cycle pulse: CPU vectors to interrupt 2.
REQ-012 status  output  8  {mask[1:0], svc_id, busy, lost2, lost1, pend2, pend1}, bits [7:0]; feeds CPU input port.

Function
REQ-013 Each irq line SHALL pass through SYNC_STAGES flops, then a rising-edge detector against one extra delayed copy.
REQ-014 Detected edge SHALL set pendN on the next clock edge; pendN is a single bit, no event counting.
REQ-015 Edge detected while pendN already 1 and not being cleared SHALL set sticky lostN; lostN cleared only by clr_lost or reset.
REQ-016 clr_lost and a new loss event in the same cycle: set wins.
REQ-017 FSM states: IDLE, FIRE1, FIRE2, SVC1, SVC2; state register and s_intrN outputs are registered.
REQ-018 IDLE -> FIRE1 when pend1 & mask[0]; else IDLE -> FIRE2 when pend2 & mask[1]; line 1 has fixed priority.
REQ-019 FIREn lasts exactly one cycle, s_intrn=1 only in FIREn, pendn cleared on the FIREn->SVCn edge; FIREn -> SVCn unconditionally.
REQ-020 New edge on line n in the same cycle pendn is cleared SHALL leave pendn=1 (set wins), no lost flag.
REQ-021 SVCn -> IDLE on iret=1; no nesting: pending requests wait in SVCn regardless of priority.
REQ-022 iret in IDLE or FIREn SHALL be ignored.
REQ-023 Masked pending request SHALL remain pending and fire once unmasked; mask change takes effect the cycle after we_mask.
REQ-024 busy=1 in FIRE1/FIRE2/SVC1/SVC2; svc_id=0 for line 1, 1 for line 2, holds last value in IDLE.
REQ-025 Latency: irq high before edge k, stable, enabled, FSM IDLE -> s_intrN high in the cycle after edge k+SYNC_STAGES+1.
REQ-026 From SVCn with iret at edge m and a pending enabled request: FIRE at edge m+1 (one IDLE cycle between services).
REQ-027 s_intr1 and s_intr2 SHALL never be high in the same cycle.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, s_intr1=s_intr2=0, pend=0, lost=0, mask=2'b00, svc_id=0, all synchronizer/edge flops=0.
REQ-029 Reset mid-service or mid-FIRE SHALL abort; after release no pulse until a fresh rising edge and enabled mask.
REQ-030 irq held high across reset release SHALL NOT be treated as an edge.

Structure
REQ-031 State encoding (3-bit) and status bit-position constants SHALL live in the shared package intr_pkg.
REQ-032 The per-line synchronizer plus edge detector SHALL be one sub-module, irq_sync, instantiated twice.

Verification
REQ-033 mask=11, single irq1 pulse -> s_intr1 one cycle after SYNC_STAGES+1 edges, status=8'hD0 in SVC1, iret -> status=8'hC0.
REQ-034 mask=11, irq1 and irq2 rise same cycle -> s_intr1 first, pend2 held (status[1]=1); iret -> s_intr2 two cycles later.
REQ-035 mask=10, irq1 edge -> no pulse, pend1=1; write mask=11 -> s_intr1 next-but-one cycle.
REQ-036 mask=00, two irq2 edges -> pend2=1, lost2=1 (status=8'h0A); clr_lost -> status=8'h02.
REQ-037 In SVC2, reset pulse low -> outputs 0, status=8'h00 asynchronously; irq2 held high after release -> no s_intr2.
REQ-038 iret strobes while IDLE with nothing pending -> no state change, no pulses.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared definitions for the two-line interrupt controller: FSM encoding
// and the bit positions of the CPU-visible status byte.
package intr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRE1 = 3'd1,
        ST_FIRE2 = 3'd2,
        ST_SVC1  = 3'd3,
        ST_SVC2  = 3'd4
    } state_t;

    localparam int STAT_PEND1   = 0;
    localparam int STAT_PEND2   = 1;
    localparam int STAT_LOST1   = 2;
    localparam int STAT_LOST2   = 3;
    localparam int STAT_BUSY    = 4;
    localparam int STAT_SVC_ID  = 5;
    localparam int STAT_MASK_LO = 6;

endpackage

// File: rtl/intr_ctrl_irq_sync.sv
// Synchronizes one asynchronous request line and flags its rising edges.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic [SYNC_STAGES:0]   r_valid;

    // r_valid fills once every compared flop holds a real post-reset sample,
    // so a line already high at reset release is not mistaken for an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '0;
            r_dly   <= 1'b0;
            r_valid <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_dly   <= r_sync[SYNC_STAGES-1];
            r_valid <= {r_valid[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign o_edge = r_valid[SYNC_STAGES] & r_sync[SYNC_STAGES-1] & ~r_dly;

endmodule

// File: rtl/intr_ctrl.sv
// Two-line interrupt controller: pending/lost tracking, masking and a
// non-nesting fixed-priority service FSM that pulses the CPU vector lines.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       irq1,
    input  logic       irq2,
    input  logic       we_mask,
    input  logic [1:0] mask_in,
    input  logic       iret,
    input  logic       clr_lost,
    output logic       s_intr1,
    output logic       s_intr2,
    output logic [7:0] status
);

    logic       w_edge1;
    logic       w_edge2;
    logic       w_clr1;
    logic       w_clr2;
    state_t     r_state;
    logic       r_intr1;
    logic       r_intr2;
    logic       r_svc_id;
    logic       r_pend1;
    logic       r_pend2;
    logic       r_lost1;
    logic       r_lost2;
    logic [1:0] r_mask;

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .clk    (clk),
        .reset  (reset),
        .i_irq  (irq1),
        .o_edge (w_edge1)
    );

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
        .clk    (clk),
        .reset  (reset),
        .i_irq  (irq2),
        .o_edge (w_edge2)
    );

    assign w_clr1 = (r_state == ST_FIRE1);
    assign w_clr2 = (r_state == ST_FIRE2);

    // A fresh edge beats the clear from FIRE; a loss needs an edge landing on
    // a request that is still pending and not being consumed this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend1 <= 1'b0;
            r_pend2 <= 1'b0;
            r_lost1 <= 1'b0;
            r_lost2 <= 1'b0;
            r_mask  <= 2'b00;
        end else begin
            r_pend1 <= w_edge1 | (r_pend1 & ~w_clr1);
            r_pend2 <= w_edge2 | (r_pend2 & ~w_clr2);
            r_lost1 <= (w_edge1 & r_pend1 & ~w_clr1) | (r_lost1 & ~clr_lost);
            r_lost2 <= (w_edge2 & r_pend2 & ~w_clr2) | (r_lost2 & ~clr_lost);
            if (we_mask) begin
                r_mask <= mask_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_intr1  <= 1'b0;
            r_intr2  <= 1'b0;
            r_svc_id <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pend1 & r_mask[0]) begin
                        r_state  <= ST_FIRE1;
                        r_intr1  <= 1'b1;
                        r_svc_id <= 1'b0;
                    end else if (r_pend2 & r_mask[1]) begin
                        r_state  <= ST_FIRE2;
                        r_intr2  <= 1'b1;
                        r_svc_id <= 1'b1;
                    end
                end
                ST_FIRE1: begin
                    r_state <= ST_SVC1;
                    r_intr1 <= 1'b0;
                end
                ST_FIRE2: begin
                    r_state <= ST_SVC2;
                    r_intr2 <= 1'b0;
                end
                ST_SVC1, ST_SVC2: begin
                    if (iret) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_intr1 <= 1'b0;
                    r_intr2 <= 1'b0;
                end
            endcase
        end
    end

    assign s_intr1 = r_intr1;
    assign s_intr2 = r_intr2;

    always_comb begin
        status                      = '0;
        status[STAT_PEND1]          = r_pend1;
        status[STAT_PEND2]          = r_pend2;
        status[STAT_LOST1]          = r_lost1;
        status[STAT_LOST2]          = r_lost2;
        status[STAT_BUSY]           = (r_state != ST_IDLE);
        status[STAT_SVC_ID]         = r_svc_id;
        status[STAT_MASK_LO +: 2]   = r_mask;
    end

endmodule
